sub_r2r3_serial: RTL and testbench
==================================

# sub_r2r3_serial

Multi-cycle serial subtractor computing r1 = r2 - r3 with N/Z/C/V flags, processing DW bits per clock, LSB first. It is the inverse-operation companion to the single-cycle adder in the ALU. It is intended for area-constrained datapath slots where a start/done handshake is acceptable. Flag conventions match the adder: C is the carry out of bit 31, so 1 means no borrow.

## Interface
Parameters:
- DW, default 1: digit width in bits processed per cycle. Legal values are 1, 2, 4, 8, 16 and 32; any other value is an elaboration error.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a subtraction; sampled only when the block is not busy.
- r2, input, 32: minuend; latched on an accepted start.
- r3, input, 32: subtrahend; latched on an accepted start.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse; r1 and the flags are valid from this cycle.
- r1, output, 32: difference.
- n, output, 1: negative flag, equal to r1[31].
- z, output, 1: zero flag, high when r1 == 0.
- c, output, 1: carry out of bit 31 of r2 + ~r3 + cin_eff; 1 means no borrow.
- v, output, 1: signed overflow flag.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: processes one digit per cycle for N = 32/DW cycles.
  - DONE: lasts one cycle, with done high.
- IDLE → RUN on start:
  - r2 and r3 are latched.
  - The digit counter is cleared.
  - The carry register is loaded with cin_eff: 1, or the cin port value under the macro.
- RUN, each cycle:
  - digit = r2_digit + ~r3_digit + carry, computed as a (DW+1)-bit sum.
  - The low DW bits are written into the result shift register.
  - The top bit becomes the next carry.
  - On the Nth digit, go to DONE.
- Entering DONE updates the outputs:
  - r1 = full result.
  - n = r1[31].
  - z = (r1 == 0).
  - c = final carry.
  - v = (r2[31] != r3[31]) && (r1[31] != r2[31]), using the latched operands.
- DONE → RUN if start is high in that cycle (back-to-back operation); otherwise DONE → IDLE.
- r1, n, z, c and v hold their values until the next operation completes. Intermediate digits are never visible on r1.
- start while in RUN is ignored, with no queuing.
- Changes to r2 and r3 after acceptance have no effect.
- Reset values: busy=0, done=0, r1=0, n=0, z=0, c=0, v=0, state IDLE.
- Reset mid-operation aborts the operation, returns all outputs to their reset values, and produces no done pulse.

## Timing
- Start sampled high at edge E0 (state IDLE or DONE): busy goes high after E0.
- done goes high after edge E0+N. r1 and the flags update at the same edge. busy goes low in that same cycle.
- Latency from start edge to done: N = 32/DW cycles. Examples: DW=1 gives 32, DW=8 gives 4, DW=32 gives 1.
- Maximum throughput is one result per N+1 cycles when start is held high or re-asserted during done.

## Configuration
- SUB_CARRY_IN_EN defined:
  - Adds port cin (input, 1 bit), latched on accepted start.
  - The initial carry equals cin, which gives SBC semantics: r1 = r2 - r3 - !cin.
  - v and c are computed over the full three-operand sum.
- SUB_CARRY_IN_EN undefined:
  - No cin port.
  - Initial carry is constant 1, giving plain subtraction r2 - r3.

## Test plan
- DW=1, r2=5, r3=3, start for 1 cycle → done exactly 32 cycles after the start edge; r1=2, n=0, z=0, c=1, v=0.
- r2=3, r3=5 → r1=0xFFFFFFFE, n=1, z=0, c=0, v=0. Repeat with DW=8; done must arrive 4 cycles after start.
- r2=0x80000000, r3=1 → r1=0x7FFFFFFF, n=0, c=1, v=1.
- r2=r3=0x12345678 → r1=0, z=1, c=1, v=0.
- Hold start high across two operations (7-2, then 2-7) → results 5 then 0xFFFFFFFB; second done lands N+1 cycles after the first. start pulses during RUN and operand changes mid-RUN leave the results unchanged.
- Deassert rst_n 10 cycles into an operation → busy=0, done=0, all outputs 0 immediately; no done follows. Under SUB_CARRY_IN_EN, cin=0 with 5-3 → r1=1, c=1.

Source files
------------

// File: rtl/sub_r2r3_serial.sv
// sub_r2r3_serial: digit-serial r1 = r2 - r3 with N/Z/C/V flags, DW bits per clock, LSB first.
// Optional macro SUB_CARRY_IN_EN adds a cin port (SBC: r1 = r2 - r3 - !cin).
module sub_r2r3_serial #(
    parameter int DW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SUB_CARRY_IN_EN
    input  logic        cin,
`endif
    input  logic        start,
    input  logic [31:0] r2,
    input  logic [31:0] r3,
    output logic        busy,
    output logic        done,
    output logic [31:0] r1,
    output logic        n,
    output logic        z,
    output logic        c,
    output logic        v
);
    localparam int N = 32 / DW;

    if (!(DW == 1 || DW == 2 || DW == 4 || DW == 8 || DW == 16 || DW == 32)) begin : g_bad_dw
        $error("sub_r2r3_serial: DW must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [31:0]   a_sh, b_sh, acc, acc_nx;
    logic          sa, sb, carry, last, accept, cin_eff;
    logic [5:0]    cnt;
    logic [DW:0]   sum;
    logic [31+DW:0] ext;

`ifdef SUB_CARRY_IN_EN
    assign cin_eff = cin;
`else
    assign cin_eff = 1'b1;
`endif

    // one digit of r2 + ~r3 + carry; new digit enters the result from the top
    always_comb begin
        sum    = {1'b0, a_sh[DW-1:0]} + {1'b0, ~b_sh[DW-1:0]} + {{DW{1'b0}}, carry};
        ext    = {sum[DW-1:0], acc};
        acc_nx = ext[31+DW:DW];
        last   = cnt == 6'(N - 1);
        accept = start && state != RUN;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and status outputs; start is honoured in IDLE and DONE only
    always_comb begin
        state_nx = accept ? RUN :
                   (state == RUN && last) ? DONE :
                   (state == DONE) ? IDLE : state;
        busy = state == RUN;
        done = state == DONE;
    end

    // operand latch, digit datapath and result/flag update on the final digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            r1    <= '0;
            n     <= 1'b0;
            z     <= 1'b0;
            c     <= 1'b0;
            v     <= 1'b0;
        end else if (accept) begin
            a_sh  <= r2;
            b_sh  <= r3;
            sa    <= r2[31];
            sb    <= r3[31];
            carry <= cin_eff;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DW;
            b_sh  <= b_sh >> DW;
            acc   <= acc_nx;
            carry <= sum[DW];
            cnt   <= cnt + 6'd1;
            if (last) begin
                r1 <= acc_nx;
                n  <= acc_nx[31];
                z  <= acc_nx == 32'd0;
                c  <= sum[DW];
                v  <= (sa != sb) && (acc_nx[31] != sa);
            end
        end
    end
endmodule

// File: tb/tb_sub_r2r3_serial.sv
// tb_sub_r2r3_serial: scoreboard bench for the serial subtractor at DW=1 and DW=8.
module tb_sub_r2r3_serial;
    typedef struct {
        logic [31:0] r1;
        logic [3:0]  f;
        int          e0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start8 = 1'b0;
    logic [31:0] a1 = '0, b1 = '0, a8 = '0, b8 = '0;
    logic        busy1, done1, n1, z1, c1, v1;
    logic        busy8, done8, n8, z8, c8, v8;
    logic [31:0] r1_1, r1_8;
`ifdef SUB_CARRY_IN_EN
    logic        cin = 1'b1;
`endif
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          e0;
    exp_t        q1[$], q8[$];

    sub_r2r3_serial #(.DW(1)) u1 (
        .clk(clk), .rst_n(rst_n),
`ifdef SUB_CARRY_IN_EN
        .cin(cin),
`endif
        .start(start1), .r2(a1), .r3(b1), .busy(busy1), .done(done1),
        .r1(r1_1), .n(n1), .z(z1), .c(c1), .v(v1));

    sub_r2r3_serial #(.DW(8)) u8 (
        .clk(clk), .rst_n(rst_n),
`ifdef SUB_CARRY_IN_EN
        .cin(cin),
`endif
        .start(start8), .r2(a8), .r3(b8), .busy(busy8), .done(done8),
        .r1(r1_8), .n(n8), .z(z8), .c(c8), .v(v8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // monitor for the DW=1 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done1) begin
            if (q1.size() == 0) check("dw1_unexpected_done", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("dw1_r1", r1_1, e.r1);
                check("dw1_nzcv", {28'd0, n1, z1, c1, v1}, {28'd0, e.f});
                check("dw1_latency", cyc - e.e0, 32);
                check("dw1_busy_at_done", {31'd0, busy1}, 32'd0);
            end
        end
    end

    // monitor for the DW=8 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done8) begin
            if (q8.size() == 0) check("dw8_unexpected_done", 32'd1, 32'd0);
            else begin
                e = q8.pop_front();
                check("dw8_r1", r1_8, e.r1);
                check("dw8_nzcv", {28'd0, n8, z8, c8, v8}, {28'd0, e.f});
                check("dw8_latency", cyc - e.e0, 4);
                check("dw8_busy_at_done", {31'd0, busy8}, 32'd0);
            end
        end
    end

    // start held high after return; caller decides when to drop it
    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef, output int e);
        @(negedge clk);
        if (sel == 8) begin start8 = 1'b1; a8 = a; b8 = b; end
        else begin start1 = 1'b1; a1 = a; b1 = b; end
        @(posedge clk);
        #1;
        e = cyc;
        if (sel == 8) q8.push_back('{er, ef, e});
        else q1.push_back('{er, ef, e});
    endtask

    task automatic wait_done(input int sel, input int budget);
        logic seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = (sel == 8) ? done8 : done1;
        end
        check(sel == 8 ? "dw8_done_timeout" : "dw1_done_timeout", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("dw1_reset_state", {busy1, done1, n1, z1, c1, v1} | r1_1, 32'd0);
        check("dw8_reset_state", {busy8, done8, n8, z8, c8, v8} | r1_8, 32'd0);
        rst_n = 1'b1;

        issue(1, 32'd5, 32'd3, 32'd2, 4'b0010, e0);
        @(negedge clk) start1 = 1'b0;
        wait_done(1, 40);

        issue(1, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1000, e0);
        @(negedge clk) start1 = 1'b0;
        wait_done(1, 40);

        issue(1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011, e0);
        @(negedge clk) start1 = 1'b0;
        repeat (5) @(negedge clk);
        start1 = 1'b1; a1 = 32'h0000FFFF; b1 = 32'h00001234;
        @(negedge clk) start1 = 1'b0; a1 = '0; b1 = 32'hFFFFFFFF;
        wait_done(1, 40);

        issue(1, 32'h12345678, 32'h12345678, 32'd0, 4'b0110, e0);
        @(negedge clk) start1 = 1'b0;
        wait_done(1, 40);

        issue(1, 32'd7, 32'd2, 32'd5, 4'b0010, e0);
        @(negedge clk) a1 = 32'd2; b1 = 32'd7;
        q1.push_back('{32'hFFFFFFFB, 4'b1000, e0 + 33});
        wait_done(1, 40);
        @(posedge clk);
        @(negedge clk) start1 = 1'b0;
        wait_done(1, 40);

        issue(1, 32'd5, 32'd3, 32'd2, 4'b0010, e0);
        @(negedge clk) start1 = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("dw1_reset_midop", {busy1, done1, n1, z1, c1, v1} | r1_1, 32'd0);
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        issue(8, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b1000, e0);
        @(negedge clk) start8 = 1'b0;
        wait_done(8, 10);
        issue(8, 32'h12345678, 32'h12345678, 32'd0, 4'b0110, e0);
        @(negedge clk) start8 = 1'b0;
        wait_done(8, 10);

`ifdef SUB_CARRY_IN_EN
        cin = 1'b0;
        issue(1, 32'd5, 32'd3, 32'd1, 4'b0010, e0);
        @(negedge clk) start1 = 1'b0;
        wait_done(1, 40);
        cin = 1'b1;
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q1.size() + q8.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
